// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bus between an upstream word source and the PISO serializer.
// The serializer owns din_ready and everything on the serial side.
interface piso_serializer_if #(
    parameter int N = 4
);
    logic [N-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         so;
    logic         so_valid;
    logic         frame_done;
    logic         busy;

    modport master (
        output din, din_valid,
        input  din_ready, so, so_valid, frame_done, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, so, so_valid, frame_done, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding a SIPO: accepts one N-bit word per handshake,
// streams it out one bit per clock, then idles for GAP cycles.
module piso_serializer #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 1
) (
    input  logic             clk,
    input  logic             rst,
    piso_serializer_if.slave bus
);

    localparam int CW = $clog2(N);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(N - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t          state;
    logic [N-1:0]    shreg;
    logic [CW-1:0]   bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            so_q;
    logic            so_valid_q;
    logic            frame_done_q;
    logic            busy_q;

    assign bus.din_ready  = (state == ST_IDLE) && !rst;
    assign bus.so         = so_q;
    assign bus.so_valid   = so_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

    // The first bit is launched on the accept edge itself, so shreg keeps only the bits still to go.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            so_q         <= 1'b0;
            so_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    so_q         <= 1'b0;
                    so_valid_q   <= 1'b0;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    if (bus.din_valid && bus.din_ready) begin
                        state      <= ST_SHIFT;
                        bit_cnt    <= '0;
                        so_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        if (MSB_FIRST) begin
                            so_q  <= bus.din[N-1];
                            shreg <= {bus.din[N-2:0], 1'b0};
                        end else begin
                            so_q  <= bus.din[0];
                            shreg <= {1'b0, bus.din[N-1:1]};
                        end
                    end
                end

                ST_SHIFT: begin
                    if (bit_cnt == BIT_LAST) begin
                        so_q         <= 1'b0;
                        so_valid_q   <= 1'b0;
                        frame_done_q <= 1'b0;
                        if (GAP > 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        bit_cnt      <= bit_cnt + 1'b1;
                        so_valid_q   <= 1'b1;
                        frame_done_q <= (bit_cnt == BIT_LAST - 1'b1);
                        if (MSB_FIRST) begin
                            so_q  <= shreg[N-1];
                            shreg <= {shreg[N-2:0], 1'b0};
                        end else begin
                            so_q  <= shreg[0];
                            shreg <= {1'b0, shreg[N-1:1]};
                        end
                    end
                end

                ST_GAP: begin
                    so_q         <= 1'b0;
                    so_valid_q   <= 1'b0;
                    frame_done_q <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    so_q         <= 1'b0;
                    so_valid_q   <= 1'b0;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule
